// File: rtl/credit_elastic_rx.sv
// credit_elastic_rx: receive side of a credit-based stream link.
// Beats are buffered in a SIZE-entry circular buffer and one credit is returned per downstream pop.
// OUT_REG=1 adds an output flop stage that is counted inside SIZE.
// Optional macro CREDIT_RX_OVERFLOW_CHECK_EN enables a sticky overflow flag and a simulation assertion.
module credit_elastic_rx #(
  parameter int unsigned DATAW   = 1,
  parameter int unsigned SIZE    = 4,
  parameter int unsigned OUT_REG = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_in,
  input  logic [DATAW-1:0]           data_in,
  output logic                       credit_out,
  output logic                       valid_out,
  output logic [DATAW-1:0]           data_out,
  input  logic                       ready_out,
  output logic [$clog2(SIZE+1)-1:0]  count,
  output logic                       overflow
);

  // The output register holds one of the SIZE entries, so the buffer is one entry smaller.
  localparam int unsigned FD = (OUT_REG != 0) ? SIZE - 1 : SIZE;
  localparam int unsigned PW = (FD > 1) ? $clog2(FD) : 1;
  localparam int unsigned CW = $clog2(SIZE + 1);

  logic [DATAW-1:0] mem_q [FD];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    fcnt_q, fcnt_d;
  logic [CW-1:0]    count_q, count_d;
  logic             credit_q;
  logic             pop;
  logic             push;
  logic             fifo_rd;

  assign pop  = valid_out & ready_out;
  // No backpressure upstream: a beat is taken if there is room or a slot frees this cycle.
  assign push = valid_in & ((count_q < CW'(SIZE)) | pop);

  // Pointer wrap and occupancy bookkeeping.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(FD - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (fifo_rd) rd_ptr_d = (rd_ptr_q == PW'(FD - 1)) ? '0 : rd_ptr_q + PW'(1);
    fcnt_d  = fcnt_q + CW'(push) - CW'(fifo_rd);
    count_d = count_q + CW'(push) - CW'(pop);
  end

  // Buffer storage, pointers, counters and the credit return pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(FD); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= data_in;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      count_q  <= count_d;
      credit_q <= pop;
    end
  end

  assign credit_out = credit_q;
  assign count      = count_q;

  if (OUT_REG != 0) begin : g_oreg
    logic             oreg_v_q;
    logic [DATAW-1:0] oreg_d_q;

    // Refill the output register whenever it is empty or being popped.
    assign fifo_rd = (fcnt_q != '0) & (~oreg_v_q | pop);

    // Output register stage.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        oreg_v_q <= 1'b0;
        oreg_d_q <= '0;
      end else if (fifo_rd) begin
        oreg_v_q <= 1'b1;
        oreg_d_q <= mem_q[rd_ptr_q];
      end else if (pop) begin
        oreg_v_q <= 1'b0;
      end
    end

    assign valid_out = oreg_v_q;
    assign data_out  = oreg_d_q;
  end else begin : g_head
    assign fifo_rd   = pop;
    assign valid_out = (fcnt_q != '0);
    assign data_out  = mem_q[rd_ptr_q];
  end

`ifdef CREDIT_RX_OVERFLOW_CHECK_EN
  logic illegal;
  logic ovf_q;

  assign illegal = valid_in & (count_q == CW'(SIZE)) & ~pop;

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else        ovf_q <= ovf_q | illegal;
  end

  assign overflow = ovf_q;

`ifndef SYNTHESIS
  logic [31:0] cyc_q;

  // Cycle counter used only to locate an overflow in the simulation log.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cyc_q <= '0;
    else        cyc_q <= cyc_q + 32'd1;
  end

  // Flag a push the transmitter had no credit for.
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!illegal)
        else $warning("credit_elastic_rx overflow: illegal push at cycle %0d, count=%0d", cyc_q, count_q);
    end
  end
`endif
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_credit_elastic_rx.sv
// Directed bench for credit_elastic_rx: three instances (SIZE=4/OUT_REG=0, SIZE=3/OUT_REG=0, SIZE=4/OUT_REG=1).
module tb_credit_elastic_rx;

`ifdef CREDIT_RX_OVERFLOW_CHECK_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance A: SIZE=4, OUT_REG=0
  logic       a_vin, a_rdy, a_cred, a_vout, a_ovf;
  logic [7:0] a_din, a_dout;
  logic [2:0] a_cnt;
  // Instance B: SIZE=3, OUT_REG=0
  logic       b_vin, b_rdy, b_cred, b_vout, b_ovf;
  logic [7:0] b_din, b_dout;
  logic [1:0] b_cnt;
  // Instance C: SIZE=4, OUT_REG=1
  logic       c_vin, c_rdy, c_cred, c_vout, c_ovf;
  logic [7:0] c_din, c_dout;
  logic [2:0] c_cnt;

  credit_elastic_rx #(.DATAW(8), .SIZE(4), .OUT_REG(0)) u_a (
    .clk(clk), .reset(reset), .valid_in(a_vin), .data_in(a_din), .credit_out(a_cred),
    .valid_out(a_vout), .data_out(a_dout), .ready_out(a_rdy), .count(a_cnt), .overflow(a_ovf));

  credit_elastic_rx #(.DATAW(8), .SIZE(3), .OUT_REG(0)) u_b (
    .clk(clk), .reset(reset), .valid_in(b_vin), .data_in(b_din), .credit_out(b_cred),
    .valid_out(b_vout), .data_out(b_dout), .ready_out(b_rdy), .count(b_cnt), .overflow(b_ovf));

  credit_elastic_rx #(.DATAW(8), .SIZE(4), .OUT_REG(1)) u_c (
    .clk(clk), .reset(reset), .valid_in(c_vin), .data_in(c_din), .credit_out(c_cred),
    .valid_out(c_vout), .data_out(c_dout), .ready_out(c_rdy), .count(c_cnt), .overflow(c_ovf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int pops;
  int creds;
  int nexp;
  int maxcnt;
  int cred_seen;

  initial begin
    reset = 1'b0;
    a_vin = 0; a_din = '0; a_rdy = 0;
    b_vin = 0; b_din = '0; b_rdy = 0;
    c_vin = 0; c_din = '0; c_rdy = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_valid", 32'(a_vout), 32'h0);
    chk("rst_a_count", 32'(a_cnt), 32'h0);
    chk("rst_a_credit", 32'(a_cred), 32'h0);
    chk("rst_a_ovf", 32'(a_ovf), 32'h0);
    chk("rst_a_data", 32'(a_dout), 32'h0);
    chk("rst_c_valid", 32'(c_vout), 32'h0);
    reset = 1'b1;
    step();

    // 1: fill SIZE=4 with ready low
    cred_seen = 0;
    for (int i = 0; i < 4; i++) begin
      a_vin = 1; a_din = 8'(8'hA0 + i);
      step();
      if (i == 0) begin
        chk("t1_valid_after_first", 32'(a_vout), 32'h1);
        chk("t1_count_first", 32'(a_cnt), 32'h1);
      end
      cred_seen += int'(a_cred);
    end
    a_vin = 0;
    step();
    cred_seen += int'(a_cred);
    chk("t1_count_full", 32'(a_cnt), 32'h4);
    chk("t1_data_head", 32'(a_dout), 32'hA0);
    chk("t1_no_credit", 32'(cred_seen), 32'h0);

    // 2: drain in order with back-to-back credits
    a_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t2_valid", 32'(a_vout), 32'h1);
      chk("t2_data", 32'(a_dout), 32'(8'hA0 + i));
      step();
      chk("t2_credit", 32'(a_cred), 32'h1);
    end
    chk("t2_count_empty", 32'(a_cnt), 32'h0);
    chk("t2_valid_empty", 32'(a_vout), 32'h0);
    step();
    chk("t2_no_credit_empty", 32'(a_cred), 32'h0);
    chk("t2_count_stays", 32'(a_cnt), 32'h0);

    // 3: push and pop together at count==SIZE
    a_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      a_vin = 1; a_din = 8'(8'hE0 + i);
      step();
    end
    chk("t3_count_full", 32'(a_cnt), 32'h4);
    a_vin = 1; a_din = 8'hB0; a_rdy = 1;
    step();
    a_vin = 0;
    chk("t3_count_same", 32'(a_cnt), 32'h4);
    chk("t3_credit", 32'(a_cred), 32'h1);
    chk("t3_ovf", 32'(a_ovf), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("t3_order", 32'(a_dout), (i < 3) ? 32'(8'hE1 + i) : 32'hB0);
      step();
    end
    chk("t3_count_end", 32'(a_cnt), 32'h0);

    // 3b: SIZE=3, ten beats across pointer wrap
    b_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      b_vin = 1; b_din = 8'(8'h30 + i);
      step();
    end
    chk("t3b_full", 32'(b_cnt), 32'h3);
    b_rdy = 1;
    for (int i = 3; i < 10; i++) begin
      b_din = 8'(8'h30 + i);
      chk("t3b_data", 32'(b_dout), 32'(8'h30 + i - 3));
      step();
      chk("t3b_count", 32'(b_cnt), 32'h3);
    end
    b_vin = 0;
    for (int i = 7; i < 10; i++) begin
      chk("t3b_tail", 32'(b_dout), 32'(8'h30 + i));
      step();
    end
    chk("t3b_empty", 32'(b_cnt), 32'h0);
    b_rdy = 0;

    // 4: illegal push while full
    a_rdy = 0;
    for (int i = 0; i < 4; i++) begin
      a_vin = 1; a_din = 8'(8'h90 + i);
      step();
    end
    a_din = 8'hC0;
    step();
    a_vin = 0;
    chk("t4_count", 32'(a_cnt), 32'h4);
    chk("t4_ovf", 32'(a_ovf), 32'(EXP_OVF));
    step();
    chk("t4_ovf_sticky", 32'(a_ovf), 32'(EXP_OVF));
    a_rdy = 1;
    for (int i = 0; i < 4; i++) begin
      chk("t4_data", 32'(a_dout), 32'(8'h90 + i));
      step();
    end
    chk("t4_no_c0", 32'(a_vout), 32'h0);
    chk("t4_ovf_after_drain", 32'(a_ovf), 32'(EXP_OVF));
    a_rdy = 0;

    // 5: OUT_REG=1 latency and streaming throughput
    c_vin = 1; c_din = 8'hD0;
    step();
    c_vin = 0;
    chk("t5_valid_t1", 32'(c_vout), 32'h0);
    step();
    chk("t5_valid_t2", 32'(c_vout), 32'h1);
    chk("t5_data_t2", 32'(c_dout), 32'hD0);
    c_rdy = 1;
    step();
    chk("t5_credit_d0", 32'(c_cred), 32'h1);
    chk("t5_empty", 32'(c_cnt), 32'h0);
    pops = 0; creds = 0; nexp = 0; maxcnt = 0;
    for (int i = 0; i < 16; i++) begin
      c_vin = 1; c_din = 8'(8'h40 + i);
      if (c_vout) begin
        chk("t5_stream_data", 32'(c_dout), 32'(8'h40 + nexp));
        nexp++; pops++;
      end
      step();
      creds += int'(c_cred);
      if (int'(c_cnt) > maxcnt) maxcnt = int'(c_cnt);
      if (i >= 1) chk("t5_valid_steady", 32'(c_vout), 32'h1);
    end
    c_vin = 0;
    for (int k = 0; k < 8 && pops < 16; k++) begin
      if (c_vout) begin
        chk("t5_stream_data", 32'(c_dout), 32'(8'h40 + nexp));
        nexp++; pops++;
      end
      step();
      creds += int'(c_cred);
      if (int'(c_cnt) > maxcnt) maxcnt = int'(c_cnt);
    end
    chk("t5_pops", 32'(pops), 32'd16);
    chk("t5_credits", 32'(creds), 32'd16);
    chk("t5_maxcount", 32'(maxcnt), 32'd2);
    c_rdy = 0;

    // 6: asynchronous reset with a credit pending
    a_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      a_vin = 1; a_din = 8'(8'h60 + i);
      step();
    end
    a_din = 8'h63; a_rdy = 1;
    step();
    a_vin = 0; a_rdy = 0;
    chk("t6_pre_count", 32'(a_cnt), 32'h3);
    chk("t6_pre_credit", 32'(a_cred), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_valid", 32'(a_vout), 32'h0);
    chk("t6_async_count", 32'(a_cnt), 32'h0);
    chk("t6_async_credit", 32'(a_cred), 32'h0);
    chk("t6_async_ovf", 32'(a_ovf), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    a_vin = 1; a_din = 8'h70;
    step();
    a_vin = 0;
    chk("t6_first_valid", 32'(a_vout), 32'h1);
    chk("t6_first_data", 32'(a_dout), 32'h70);
    chk("t6_first_count", 32'(a_cnt), 32'h1);
    chk("t6_first_credit", 32'(a_cred), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
